// File: rtl/oram_cmd_sequencer.sv
// oram_cmd_sequencer: expands packed harness commands into PathORAM frontend
// block requests (burst writes with generated data, burst reads with a cap on
// blocks in flight) and forwards read beats back toward the UART serializer.
//
// state | meaning
// ------+-------------------------------------------------------------
// Idle  | accepting a command from the deserializer
// Issue | presenting a block command (read or write) at curAddr
// WData | streaming the write beats of the current block
// Drain | terminate received, waiting for all read blocks to return
// Halt  | terminate complete, no further commands accepted
module oram_cmd_sequencer #(
    parameter int ORAMU          = 32,
    parameter int ORAMB          = 512,
    parameter int FEDWidth       = 64,
    parameter int MaxOutstanding = 4
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic [103:0]        CmdIn,
    input  logic                CmdInValid,
    output logic                CmdInReady,
    output logic [1:0]          ORAMCommand,
    output logic [ORAMU-1:0]    ORAMPAddr,
    output logic                ORAMCommandValid,
    input  logic                ORAMCommandReady,
    output logic [FEDWidth-1:0] ORAMDataIn,
    output logic                ORAMDataInValid,
    input  logic                ORAMDataInReady,
    input  logic [FEDWidth-1:0] ORAMDataOut,
    input  logic                ORAMDataOutValid,
    output logic                ORAMDataOutReady,
    output logic [FEDWidth-1:0] RespData,
    output logic                RespValid,
    input  logic                RespReady,
    output logic                Done,
    output logic [7:0]          BadOpCount
);
    localparam int BeatsPerBlock = ORAMB / FEDWidth;
    localparam int BeatW         = (BeatsPerBlock > 1) ? $clog2(BeatsPerBlock) : 1;
    localparam int OutW          = $clog2(MaxOutstanding + 1);
    localparam logic [BeatW-1:0] LastBeat = BeatW'(BeatsPerBlock - 1);
    localparam logic [OutW-1:0]  OutMax   = OutW'(MaxOutstanding);

    typedef enum logic [2:0] {Idle, Issue, WData, Drain, Halt} stateT;

    stateT             state;
    logic              isRead;
    logic [ORAMU-1:0]  curAddr;
    logic [31:0]       curData;
    logic [31:0]       remaining;
    logic [BeatW-1:0]  beatIdx;
    logic [BeatW-1:0]  retBeat;
    logic [OutW-1:0]   outstanding;
    logic              doneReg;
    logic [7:0]        badOpReg;

    logic cmdFire, oramCmdFire, dataFire, retFire, blockDone, readIssue, retire;

    assign cmdFire     = CmdInValid && CmdInReady;
    assign oramCmdFire = ORAMCommandValid && ORAMCommandReady;
    assign dataFire    = ORAMDataInValid && ORAMDataInReady;
    assign retFire     = ORAMDataOutValid && ORAMDataOutReady;
    assign blockDone   = retFire && (retBeat == LastBeat);
    assign readIssue   = oramCmdFire && isRead;
    // Beats from reads abandoned by a reset must not underflow the count.
    assign retire      = blockDone && (outstanding != '0);

    // Ready is held low while Reset is asserted, before the state register settles.
    assign CmdInReady       = Reset && (state == Idle);
    assign ORAMCommand      = isRead ? 2'b01 : 2'b00;
    assign ORAMPAddr        = curAddr;
    assign ORAMCommandValid = (state == Issue) && !(isRead && (outstanding == OutMax));
    assign ORAMDataInValid  = (state == WData);
    assign ORAMDataIn       = {curData, (FEDWidth - 32)'(beatIdx)};
    assign RespData         = ORAMDataOut;
    assign RespValid        = ORAMDataOutValid;
    assign ORAMDataOutReady = RespReady;
    assign Done             = doneReg;
    assign BadOpCount       = badOpReg;

    // Command sequencing FSM.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state     <= Idle;
            isRead    <= 1'b0;
            curAddr   <= '0;
            curData   <= '0;
            remaining <= '0;
            beatIdx   <= '0;
            doneReg   <= 1'b0;
            badOpReg  <= '0;
        end else begin
            doneReg <= 1'b0;
            case (state)
                Idle: begin
                    if (cmdFire) begin
                        curAddr   <= ORAMU'(CmdIn[95:64]);
                        curData   <= CmdIn[63:32];
                        remaining <= CmdIn[31:0];
                        case (CmdIn[103:96])
                            8'h00: begin
                                isRead <= 1'b0;
                                state  <= Issue;
                            end
                            8'h02: begin
                                isRead <= 1'b1;
                                state  <= Issue;
                            end
                            8'hFF: state <= Drain;
                            default: begin
                                if (badOpReg != 8'hFF) badOpReg <= badOpReg + 8'd1;
                            end
                        endcase
                    end
                end
                Issue: begin
                    if (oramCmdFire) begin
                        if (isRead) begin
                            if (remaining == 32'd0) begin
                                state <= Idle;
                            end else begin
                                remaining <= remaining - 32'd1;
                                curAddr   <= curAddr + ORAMU'(1);
                            end
                        end else begin
                            beatIdx <= '0;
                            state   <= WData;
                        end
                    end
                end
                WData: begin
                    if (dataFire) begin
                        if (beatIdx == LastBeat) begin
                            beatIdx <= '0;
                            if (remaining == 32'd0) begin
                                state <= Idle;
                            end else begin
                                remaining <= remaining - 32'd1;
                                curAddr   <= curAddr + ORAMU'(1);
                                curData   <= curData + 32'd1;
                                state     <= Issue;
                            end
                        end else begin
                            beatIdx <= beatIdx + BeatW'(1);
                        end
                    end
                end
                Drain: begin
                    if ((outstanding == '0) && (retBeat == '0)) begin
                        doneReg <= 1'b1;
                        state   <= Halt;
                    end
                end
                Halt: ;
                default: state <= Idle;
            endcase
        end
    end

    // Return-beat position within the current read block.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            retBeat <= '0;
        end else if (retFire) begin
            retBeat <= (retBeat == LastBeat) ? '0 : retBeat + BeatW'(1);
        end
    end

    // Read blocks issued but not yet fully returned; issue and retire together cancel.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            outstanding <= '0;
        end else begin
            case ({readIssue, retire})
                2'b10:   outstanding <= outstanding + OutW'(1);
                2'b01:   outstanding <= outstanding - OutW'(1);
                default: ;
            endcase
        end
    end
endmodule

// File: doc/oram_cmd_sequencer.md
# oram_cmd_sequencer

Expands test-harness commands into ORAM frontend block requests. Each command is a packed {opcode, address, data, count} word that arrives from the UART deserializer. The block sequences burst writes with generated data and burst reads, and it bounds the number of reads in flight. Read data is forwarded back toward the UART serializer, and a terminate command drains all traffic before reporting completion. It sits between the UART/FIFOShiftRound harness logic and the PathORAM frontend command and data ports.

## Interface
Parameters:
- ORAMU, 32, program-address width
- ORAMB, 512, block size in bits
- FEDWidth, 64, frontend data width; BeatsPerBlock = ORAMB/FEDWidth (8 at defaults)
- MaxOutstanding, 4, maximum read blocks issued but not fully returned (power of two, ≥1)

Ports:
- Clock  in  1  sole clock
- Reset  in  1  synchronous, active-low (Reset==0 resets on the rising Clock edge)
- CmdIn  in  104  {Op[103:96], Addr[95:64], Data[63:32], Count[31:0]}
- CmdInValid / CmdInReady  in / out  1  command handshake
- ORAMCommand  out  2  2'b00 = write, 2'b01 = read
- ORAMPAddr  out  ORAMU  block address
- ORAMCommandValid / ORAMCommandReady  out / in  1
- ORAMDataIn  out  FEDWidth  write data beat
- ORAMDataInValid / ORAMDataInReady  out / in  1
- ORAMDataOut  in  FEDWidth  read data beat
- ORAMDataOutValid / ORAMDataOutReady  in / out  1
- RespData  out  FEDWidth  read beat toward UART
- RespValid / RespReady  out / in  1
- Done  out  1  single-cycle pulse when terminate completes
- BadOpCount  out  8  saturating count of unrecognised opcodes

## Operation
- A transfer occurs on any handshake when Valid && Ready are both high on a rising edge.
- FSM states are Idle, Issue, WData, Drain and Halt.
- **Idle**
  - CmdInReady=1.
  - On acceptance, latch Addr into CurAddr, Data into CurData and Count into Remaining.
  - Op 8'h00 → Issue (write). Op 8'h02 → Issue (read). Op 8'hFF → Drain.
  - Any other op: discard the command, increment BadOpCount (saturating at 255), stay in Idle.
- **Issue**
  - Drive ORAMCommandValid=1 with ORAMPAddr=CurAddr.
  - For reads, ORAMCommandValid is gated low while Outstanding==MaxOutstanding.
  - On a write handshake → WData with BeatIdx=0.
  - On a read handshake: Outstanding increments. If Remaining==0 → Idle; otherwise Remaining−1, CurAddr+1, stay in Issue.
- **WData**
  - ORAMDataInValid=1 with ORAMDataIn = {CurData, 32'(BeatIdx)}; the upper 32 bits carry the data, the lower bits the zero-extended beat index, zero-padded when FEDWidth≠64.
  - On each handshake BeatIdx increments.
  - After the beat with BeatIdx==BeatsPerBlock−1: if Remaining==0 → Idle; else Remaining−1, CurAddr+1, CurData+1, → Issue.
- **Read return path**
  - Combinational pass-through: RespData=ORAMDataOut, RespValid=ORAMDataOutValid, ORAMDataOutReady=RespReady. It operates in every state.
  - A return-beat counter wraps at BeatsPerBlock. On each wrap, Outstanding decrements.
  - If an issue and a block completion happen in the same cycle, Outstanding is unchanged.
- **Drain**: wait for Outstanding==0 and no partial return block, then pulse Done for one cycle → Halt.
- **Halt**: CmdInReady=0 permanently. Only reset exits Halt.
- **Address arithmetic**
  - CurAddr wraps modulo 2^ORAMU and CurData modulo 2^32.
  - Count is the number of blocks minus one, so Count=0 means one block.

## Timing
- **Reset values**: CmdInReady=0 during reset and 1 on the first cycle after it; all Valid outputs 0; Done=0; BadOpCount=0; Outstanding=0; state Idle.
- **Command latency**: ORAMCommandValid rises the cycle after command acceptance (registered).
- **Reads**: back-to-back read commands are possible, one per cycle while the ORAM is ready and under the limit.
- **Writes**
  - Command-to-first-beat is 1 cycle: ORAMDataInValid rises the cycle after the command handshake.
  - Beats then stream at 1 per cycle under ORAMDataInReady=1.
  - The next write command is presented the cycle after the last beat.
- **Valid hold rule**: once asserted, a Valid and its data are held stable until the handshake. The block never withdraws Valid.
- **Done**: asserted the cycle after the Drain condition is first true.
- **Reset mid-operation**: Reset=0 in any state returns to the reset values on that edge. In-flight ORAM transactions are abandoned, and any read beats returned later are still passed through.

## Test plan
- **Single write**: Op 00, Addr 0x38C, Data 0x0F, Count 0 → one command (00, 0x38C), then 8 beats {0x0F, 0..7}, then CmdInReady returns to 1.
- **Burst read**: Op 02, Addr 0x38C, Count 99, ORAM model always ready → 100 read commands at 0x38C..0x3EF, 800 RespData beats in order.
- **Outstanding limit**: hold ORAMDataOutValid=0 during a read with Count 9 → exactly 4 read commands, then ORAMCommandValid stays 0. Releasing one block of 8 beats allows exactly one more command.
- **Write backpressure and wrap**
  - Op 00, Addr 0xFFFFFFFF, Data 0xFFFFFFFF, Count 1, with ORAMDataInReady toggling → addresses 0xFFFFFFFF then 0x0, and data 0xFFFFFFFF then 0x0.
  - No beat is dropped or duplicated.
- **Terminate**: after the burst read, Op FF → Done pulses exactly once, one cycle after the 800th beat. CmdInReady stays 0 afterwards. Op 0x07 earlier in the stream → BadOpCount=1.
- **Reset mid-write**: Reset=0 during beat 3 → on the next cycle all Valid outputs are 0 and CmdInReady=1.
